multiport_register_file: RTL and testbench
==========================================

MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 32, register data width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, number of registers (power of two, >= 2).
REQ-003 SHALL have parameter RD_PORTS, default 2, number of independent read ports (1..4).
REQ-004 SHALL have parameter ZERO_REG, default 0, where 1 hardwires register 0 to zero.
REQ-005 SHALL derive localparam ADDR_W = $clog2(DEPTH).
REQ-006 SHALL have port clk  input  1  rising-edge clock.
REQ-007 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-008 SHALL have port we  input  1  write enable.
REQ-009 SHALL have port waddr  input  ADDR_W  write address.
REQ-010 SHALL have port wdata  input  WIDTH  write data.
REQ-011 SHALL have port raddr  input  RD_PORTS*ADDR_W  read addresses, with port i at bits [i*ADDR_W +: ADDR_W].
REQ-012 SHALL have port rdata  output  RD_PORTS*WIDTH  read data, with port i at bits [i*WIDTH +: WIDTH].
REQ-013 SHALL have port clr_req  input  1  single-cycle request to clear all registers.
REQ-014 SHALL have port busy  output  1  high while the clear sequence runs.
REQ-015 SHALL have port wr_err  output  1  registered one-cycle pulse flagging a rejected write.

Function
REQ-016 SHALL use a two-state FSM: IDLE and CLEAR.
REQ-017 SHALL, in CLEAR, write zero to register clr_cnt each cycle, increment clr_cnt, and go to IDLE after clr_cnt == DEPTH-1, so a clear takes exactly DEPTH cycles.
REQ-018 SHALL, in IDLE with clr_req=1, enter CLEAR on the next edge with clr_cnt=0; clr_req during CLEAR SHALL be ignored without restarting the count.
REQ-019 SHALL drive busy high exactly when the state is CLEAR.
REQ-020 SHALL, in IDLE with we=1, write wdata to register waddr on the rising edge.
REQ-021 SHALL, when ZERO_REG=1 and waddr=0, discard the write and pulse wr_err.
REQ-022 SHALL, when we=1 while busy=1, discard the write and pulse wr_err on the next cycle.
REQ-023 SHALL, when we=1 and clr_req=1 coincide in IDLE, perform the write; the following clear then zeroes that register.
REQ-024 SHALL make reads combinational, with rdata[i] = reg[raddr[i]] in the same cycle.
REQ-025 SHALL force every rdata[i] to zero while busy=1.
REQ-026 SHALL return zero for register 0 when ZERO_REG=1.
REQ-027 SHALL serve any number of read ports addressing the same register with identical data.

Reset
REQ-028 SHALL, while rst_n=0, set state=CLEAR, clr_cnt=0, busy=1, wr_err=0, and rdata=0.
REQ-029 SHALL, after rst_n is released, run the full DEPTH-cycle clear; busy SHALL fall on edge DEPTH.
REQ-030 SHALL not reset the storage array asynchronously; the clear sequence initialises it.
REQ-031 SHALL, on rst_n assertion mid-clear or mid-write, abort the operation and restart the clear from clr_cnt=0 after release.

Configuration
REQ-032 SHALL support macro REGFILE_BYPASS_EN.
REQ-033 SHALL, when REGFILE_BYPASS_EN is defined and we=1, busy=0, raddr[i]==waddr and the write is legal, drive rdata[i]=wdata in the same cycle (write-to-read forwarding).
REQ-034 SHALL, when REGFILE_BYPASS_EN is undefined, return the old register value until the write edge.

Structure
REQ-035 SHALL place the FSM state enum (IDLE, CLEAR) and the default WIDTH/DEPTH/RD_PORTS constants in the shared package regfile_pkg.
REQ-036 SHALL implement the clear FSM, counter and wr_err logic in sub-module regfile_clear_ctrl, with the top level holding the array, read muxes and bypass.

Verification
REQ-037 SHALL check reset release: busy=1 for 8 cycles (DEPTH=8), then busy=0 and all ports read 32'd0.
REQ-038 SHALL check a write of 32'd30 to reg 1 then raddr={3'd1,3'd1}: both ports read 30 on the next cycle.
REQ-039 SHALL check the bypass: write 32'hDEAD_BEEF to reg 5 with raddr[0]=5 in the same cycle, reading DEADBEEF with REGFILE_BYPASS_EN defined and the old value without it.
REQ-040 SHALL check clr_req after loading regs 0..7 with 1..8: busy high 8 cycles, all reads 0 afterwards, and a write issued mid-clear pulses wr_err and is dropped.
REQ-041 SHALL check ZERO_REG=1: a write of 32'd7 to reg 0 pulses wr_err and reg 0 reads 0.
REQ-042 SHALL check rst_n asserted at clear cycle 3: after release busy lasts a full 8 cycles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the multiport register file:
// default geometry constants and the clear-sequencer state encoding.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read forwarding).
package regfile_pkg;

    localparam int DEF_WIDTH    = 32;
    localparam int DEF_DEPTH    = 8;
    localparam int DEF_RD_PORTS = 2;

    // Legacy-compatible state codes; the enum below is built from them
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    typedef enum logic [0:0] {
        IDLE  = S_IDLE,
        CLEAR = S_CLEAR
    } clrState_e;

endpackage

// File: rtl/regfile_clear_ctrl.sv
// Clear sequencer and write-legality logic for the register file.
// Walks clrCnt over every register after reset or on clr_req, decides
// whether a requested write may reach the array, and raises a one-cycle
// wr_err pulse for any write that is dropped.
// The current FSM state is exported on clrState for observation.
module regfile_clear_ctrl
    import regfile_pkg::*;
#(
    parameter int DEPTH    = DEF_DEPTH,
    parameter int ZERO_REG = 0,
    parameter int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic              clr_req,
    output clrState_e         clrState,
    output logic [ADDR_W-1:0] clrCnt,
    output logic              wrEn,
    output logic              wrErr
);

    clrState_e state;
    logic      inClear;
    logic      zeroHit;

    assign inClear  = (state == CLEAR);
    assign zeroHit  = (ZERO_REG != 0) && (waddr == '0);
    assign wrEn     = we && !inClear && !zeroHit;
    assign clrState = state;

    // Clear FSM and counter; reset parks in CLEAR so the array gets initialised
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= CLEAR;
            clrCnt <= '0;
        end else if (state == IDLE) begin
            if (clr_req) begin
                state  <= CLEAR;
                clrCnt <= '0;
            end
        end else begin
            // clr_req is ignored here: the sweep always runs to completion
            if (clrCnt == ADDR_W'(DEPTH - 1)) begin
                state <= IDLE;
            end
            clrCnt <= clrCnt + 1'b1;
        end
    end

    // One-cycle error pulse for writes dropped by a clear or the hardwired zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrErr <= 1'b0;
        end else begin
            wrErr <= we && (inClear || zeroHit);
        end
    end

endmodule

// File: rtl/multiport_register_file.sv
// Multiport register file: one write port, RD_PORTS combinational read ports.
// Holds the storage array, the read muxes and the optional forwarding path;
// sequencing of the clear sweep lives in regfile_clear_ctrl.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a legal write
// is forwarded to any read port addressing the same register in that cycle.
module multiport_register_file
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int RD_PORTS = DEF_RD_PORTS,
    parameter int ZERO_REG = 0,
    localparam int ADDR_W  = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [WIDTH-1:0]           wdata,
    input  logic [RD_PORTS*ADDR_W-1:0] raddr,
    output logic [RD_PORTS*WIDTH-1:0]  rdata,
    input  logic                       clr_req,
    output logic                       busy,
    output logic                       wr_err
);

    logic [WIDTH-1:0]  mem [DEPTH];
    clrState_e         clrState;
    logic [ADDR_W-1:0] clrCnt;
    logic              wrEn;

    regfile_clear_ctrl #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .ADDR_W   (ADDR_W)
    ) uClearCtrl (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (we),
        .waddr    (waddr),
        .clr_req  (clr_req),
        .clrState (clrState),
        .clrCnt   (clrCnt),
        .wrEn     (wrEn),
        .wrErr    (wr_err)
    );

    assign busy = (clrState == CLEAR);

    // Storage update: the clear sweep owns the array while busy, otherwise legal writes land
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clrCnt] <= '0;
        end else if (wrEn) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read muxes with optional forwarding and zero masking
    always_comb begin
        logic [ADDR_W-1:0] rdAddr;
        logic [WIDTH-1:0]  rdWord;
        rdata  = '0;
        rdAddr = '0;
        rdWord = '0;
        for (int i = 0; i < RD_PORTS; i++) begin
            rdAddr = raddr[i*ADDR_W +: ADDR_W];
            rdWord = mem[rdAddr];
`ifdef REGFILE_BYPASS_EN
            if (wrEn && (rdAddr == waddr)) begin
                rdWord = wdata;
            end
`endif
            if (busy || ((ZERO_REG != 0) && (rdAddr == '0))) begin
                rdWord = '0;
            end
            rdata[i*WIDTH +: WIDTH] = rdWord;
        end
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Directed testbench for multiport_register_file (WIDTH=32, DEPTH=8, 2 read ports).
// Two instances share all inputs: dut (ZERO_REG=0) and dutZ (ZERO_REG=1).
// Handshake: there is none; inputs are applied 1 time unit after a rising
// edge and outputs are checked at that point, away from the active edge.
module tb_multiport_register_file;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        we;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [5:0]  raddr;
    logic        clr_req;
    logic [63:0] rdata;
    logic        busy;
    logic        wr_err;
    logic [63:0] zRdata;
    logic        zBusy;
    logic        zWrErr;

    logic [31:0] rd0, rd1, zRd0;
    assign rd0  = rdata[31:0];
    assign rd1  = rdata[63:32];
    assign zRd0 = zRdata[31:0];

    int compared   = 0;
    int mismatched = 0;

    multiport_register_file #(
        .WIDTH(32), .DEPTH(8), .RD_PORTS(2), .ZERO_REG(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .clr_req(clr_req), .busy(busy), .wr_err(wr_err)
    );

    multiport_register_file #(
        .WIDTH(32), .DEPTH(8), .RD_PORTS(2), .ZERO_REG(1)
    ) dutZ (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(zRdata), .clr_req(clr_req), .busy(zBusy), .wr_err(zWrErr)
    );

    // clock
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setRead(input logic [2:0] a0, input logic [2:0] a1);
        raddr = {a1, a0};
        #1;
    endtask

    initial begin
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; raddr = '0; clr_req = 1'b0;
        tick(); tick();

        // reset state
        check("rst_busy", busy, 1);
        check("rst_wr_err", wr_err, 0);
        check("rst_rd0", rd0, 0);
        check("rst_rd1", rd1, 0);

        // release reset: exactly 8 busy cycles
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("rel_busy_%0d", k), busy, 1);
            tick();
        end
        check("rel_busy_end", busy, 0);
        check("rel_zbusy_end", zBusy, 0);
        for (int i = 0; i < 8; i++) begin
            setRead(3'(i), 3'(7 - i));
            check($sformatf("rel_rd0_%0d", i), rd0, 0);
            check($sformatf("rel_rd1_%0d", i), rd1, 0);
        end

        // write 30 to reg 1, both ports read it next cycle
        we = 1'b1; waddr = 3'd1; wdata = 32'd30; raddr = {3'd1, 3'd1};
        tick();
        we = 1'b0;
        #1;
        check("w1_rd0", rd0, 32'd30);
        check("w1_rd1", rd1, 32'd30);
        check("w1_wr_err", wr_err, 0);

        // bypass: write DEADBEEF to reg 5 while port 0 reads reg 5
        we = 1'b1; waddr = 3'd5; wdata = 32'hDEAD_BEEF; raddr = {3'd1, 3'd5};
        #1;
`ifdef REGFILE_BYPASS_EN
        check("byp_same_cycle", rd0, 32'hDEAD_BEEF);
`else
        check("byp_same_cycle", rd0, 32'd0);
`endif
        check("byp_other_port", rd1, 32'd30);
        tick();
        we = 1'b0;
        #1;
        check("byp_after_edge", rd0, 32'hDEAD_BEEF);

        // load regs 0..7 with 1..8
        for (int i = 0; i < 8; i++) begin
            we = 1'b1; waddr = 3'(i); wdata = 32'(i + 1);
            tick();
        end
        we = 1'b0;
        setRead(3'd0, 3'd7);
        check("load_r0", rd0, 32'd1);
        check("load_r7", rd1, 32'd8);
        setRead(3'd5, 3'd2);
        check("load_r5", rd0, 32'd6);
        check("load_r2", rd1, 32'd3);

        // clear request: 8 busy cycles, mid-clear write dropped with wr_err,
        // a repeated clr_req during the sweep does not restart it
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        raddr = {3'd7, 3'd0};
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("clr_busy_%0d", k), busy, 1);
            if (k == 1) begin
                check("clr_rd0_masked", rd0, 0);
                check("clr_rd1_masked", rd1, 0);
            end
            if (k == 3) begin
                we = 1'b1; waddr = 3'd2; wdata = 32'd99;
            end
            if (k == 4) begin
                check("clr_wr_err_pulse", wr_err, 1);
                we = 1'b0;
            end
            if (k == 5) begin
                check("clr_wr_err_drop", wr_err, 0);
                clr_req = 1'b1;
            end
            if (k == 6) clr_req = 1'b0;
            tick();
        end
        check("clr_busy_end", busy, 0);
        for (int i = 0; i < 8; i++) begin
            setRead(3'(i), 3'(i));
            check($sformatf("clr_rd_%0d", i), rd0, 0);
        end
        check("clr_rd1_same", rd1, 0);

        // ZERO_REG: write 7 to reg 0
        we = 1'b1; waddr = 3'd0; wdata = 32'd7; raddr = {3'd0, 3'd0};
        tick();
        we = 1'b0;
        #1;
        check("z_wr_err", zWrErr, 1);
        check("z_rd0", zRd0, 0);
        check("nz_wr_err", wr_err, 0);
        check("nz_rd0", rd0, 32'd7);
        tick();
        check("z_wr_err_fall", zWrErr, 0);

        // write and clear request together: write lands, then the sweep zeroes it
        we = 1'b1; waddr = 3'd3; wdata = 32'd55; clr_req = 1'b1; raddr = {3'd3, 3'd3};
        tick();
        we = 1'b0; clr_req = 1'b0;
        #1;
        check("co_busy", busy, 1);
        check("co_wr_err", wr_err, 0);
        for (int k = 0; k < 8; k++) tick();
        check("co_busy_end", busy, 0);
        check("co_rd3", rd0, 0);

        // reset asserted at clear cycle 3 restarts a full sweep
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        check("mr_busy_in_rst", busy, 1);
        check("mr_rd_in_rst", rd0, 0);
        tick(); tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("mr_busy_%0d", k), busy, 1);
            tick();
        end
        check("mr_busy_end", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
